hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It detects load-use hazards against the ID/EX register and drives a bubble into it, and flushes IF/ID on taken branches/jumps resolved in ID. It freezes every pipeline register while a data-memory access is outstanding, with a timeout error. It also keeps a saturating stall-cycle performance counter. It sits beside the hazard-free datapath and drives the write-enable/flush/bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
//
// Detects load-use hazards against the ID/EX register and drives a bubble
// into it, and flushes IF/ID on branches or jumps resolved taken in ID. It
// freezes every pipeline register while a data-memory access is
// outstanding, and raises a sticky error if that wait runs too long. A
// saturating counter records the cycles in which the PC was not advanced.
//
// Handshake: the memory access is a level request. mem_req_i is held high by
// the MEM stage for as long as the access is pending. A cycle with
// mem_req_i=1 and mem_ready_i=1 completes the access and is not stalled. If
// mem_req_i drops while the access is still waiting, the wait is abandoned.
//
// Ports:
//   clk_i, rst_i          clock (rising edge) and asynchronous active-high reset
//   id_rs_addr_i          rs field of the instruction in ID
//   id_rt_addr_i          rt field of the instruction in ID
//   id_uses_rt_i          the instruction in ID reads rt as a source
//   ex_mem_read_i         the instruction at the ID/EX output is a load
//   ex_rt_addr_i          destination register of that load
//   branch_taken_i        branch/jump in ID resolved taken this cycle
//   mem_req_i             MEM stage issuing a data-memory access
//   mem_ready_i           data memory completes the access this cycle
//   pc_write_o            PC update enable
//   ifid_write_o          IF/ID load enable
//   ifid_flush_o          IF/ID cleared to NOP on the next edge
//   idex_bubble_o         zero all control fields entering ID/EX
//   pipe_hold_o           hold ID/EX, EX/MEM and MEM/WB
//   err_o                 sticky memory-timeout error
//   state_o               FSM state: 0 RUN, 1 MEM_WAIT, 2 ERROR
//   stall_cnt_o           saturating count of cycles with pc_write_o=0
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_addr_i,
    input  logic [4:0]       id_rt_addr_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_mem_read_i,
    input  logic [4:0]       ex_rt_addr_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_hold_o,
    output logic             err_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERROR    = 2'd2
    } state_t;

    // The wait counter never has to hold more than MEM_TIMEOUT-1.
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t            state, state_n;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;
    logic              err_q, err_n;
    logic [CNT_W-1:0]  stall_cnt;

    logic mem_stall;
    logic load_use;

    assign mem_stall = mem_req_i & ~mem_ready_i;

    // Register 0 is hard-wired, so a load to it can never create a hazard.
    assign load_use = ex_mem_read_i && (ex_rt_addr_i != 5'd0) &&
                      ((ex_rt_addr_i == id_rs_addr_i) ||
                       (id_uses_rt_i && (ex_rt_addr_i == id_rt_addr_i)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_RUN;
            wait_cnt  <= '0;
            err_q     <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            err_q    <= err_n;
            if (!pc_write_o && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_hold_o   = 1'b0;
        state_n       = state;
        wait_cnt_n    = wait_cnt;
        err_n         = err_q;

        // Memory hold outranks the load-use bubble, which in turn outranks
        // the branch flush: a branch that depends on the load simply
        // re-resolves next cycle with forwarded data.
        if ((state == S_ERROR) || mem_stall) begin
            pipe_hold_o  = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (load_use) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
        end

        case (state)
            S_RUN: begin
                if (mem_stall) begin
                    state_n    = S_MEM_WAIT;
                    wait_cnt_n = WAIT_ONE;
                end
            end
            S_MEM_WAIT: begin
                if (!mem_req_i || mem_ready_i) begin
                    // Access completed or requester withdrew.
                    state_n    = S_RUN;
                    wait_cnt_n = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_n = S_ERROR;
                    err_n   = 1'b1;
                end else begin
                    wait_cnt_n = wait_cnt + WAIT_ONE;
                end
            end
            S_ERROR: begin
                state_n = S_ERROR;
            end
            default: begin
                state_n    = S_RUN;
                wait_cnt_n = '0;
            end
        endcase
    end

    assign err_o       = err_q;
    assign state_o     = state;
    assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    // Control bundle order: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}
    localparam logic [4:0] C_NORMAL = 5'b11000;
    localparam logic [4:0] C_BRANCH = 5'b11100;
    localparam logic [4:0] C_LDUSE  = 5'b00010;
    localparam logic [4:0] C_HOLD   = 5'b00001;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] id_rs_addr_i, id_rt_addr_i, ex_rt_addr_i;
    logic       id_uses_rt_i, ex_mem_read_i, branch_taken_i, mem_req_i, mem_ready_i;

    logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o, err_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o;

    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_pipe_hold, s_err;
    logic [1:0]  s_state;
    logic [3:0]  s_stall_cnt;

    int checks = 0;
    int passed = 0;

    // clock / reset block
    always #5 clk_i = ~clk_i;

    hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i), .id_uses_rt_i(id_uses_rt_i),
        .ex_mem_read_i(ex_mem_read_i), .ex_rt_addr_i(ex_rt_addr_i),
        .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
        .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
        .idex_bubble_o(idex_bubble_o), .pipe_hold_o(pipe_hold_o), .err_o(err_o),
        .state_o(state_o), .stall_cnt_o(stall_cnt_o)
    );

    // Narrow counter instance for the saturation check.
    hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i), .id_uses_rt_i(id_uses_rt_i),
        .ex_mem_read_i(ex_mem_read_i), .ex_rt_addr_i(ex_rt_addr_i),
        .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
        .pc_write_o(s_pc_write), .ifid_write_o(s_ifid_write), .ifid_flush_o(s_ifid_flush),
        .idex_bubble_o(s_idex_bubble), .pipe_hold_o(s_pipe_hold), .err_o(s_err),
        .state_o(s_state), .stall_cnt_o(s_stall_cnt)
    );

    logic [4:0] ctl;
    assign ctl = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs_addr_i   = 5'd0;
        id_rt_addr_i   = 5'd0;
        id_uses_rt_i   = 1'b0;
        ex_mem_read_i  = 1'b0;
        ex_rt_addr_i   = 5'd0;
        branch_taken_i = 1'b0;
        mem_req_i      = 1'b0;
        mem_ready_i    = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_mem_read_i = 1'b1;
        ex_rt_addr_i  = rd;
        id_rs_addr_i  = rd;
    endtask

    task automatic pulse_reset();
        #2 rst_i = 1'b1;
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_cnt", 32'(stall_cnt_o), 32'd0);
        chk("rst_sat_cnt", 32'(s_stall_cnt), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        #3;
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);
        chk("reset_cnt", 32'(stall_cnt_o), 32'd0);
        chk("reset_ctl", 32'(ctl), 32'(C_NORMAL));
        @(negedge clk_i);
        rst_i = 1'b0;

        // Load-use on rs: one bubble cycle, then normal.
        set_load_use(5'd8);
        #1 chk("lduse_ctl", 32'(ctl), 32'(C_LDUSE));
        tick();
        ex_mem_read_i = 1'b0;
        #1 chk("lduse_after_ctl", 32'(ctl), 32'(C_NORMAL));
        chk("lduse_cnt", 32'(stall_cnt_o), 32'd1);

        // No false stall: destination r0, or rt match without rt use.
        ex_mem_read_i = 1'b1; ex_rt_addr_i = 5'd0; id_rs_addr_i = 5'd0;
        #1 chk("r0_no_stall", 32'(ctl), 32'(C_NORMAL));
        ex_rt_addr_i = 5'd9; id_rt_addr_i = 5'd9; id_rs_addr_i = 5'd3; id_uses_rt_i = 1'b0;
        #1 chk("rt_unused_no_stall", 32'(ctl), 32'(C_NORMAL));
        id_uses_rt_i = 1'b1;
        #1 chk("rt_used_stall", 32'(ctl), 32'(C_LDUSE));
        ex_mem_read_i = 1'b0;
        #1 chk("no_load_no_stall", 32'(ctl), 32'(C_NORMAL));
        idle_inputs();
        tick();
        chk("cnt_after_nostall", 32'(stall_cnt_o), 32'd1);

        // Branch together with load-use: bubble only; branch flushes next cycle.
        set_load_use(5'd5);
        branch_taken_i = 1'b1;
        #1 chk("br_lduse_ctl", 32'(ctl), 32'(C_LDUSE));
        tick();
        ex_mem_read_i = 1'b0;
        #1 chk("br_after_ctl", 32'(ctl), 32'(C_BRANCH));
        tick();
        chk("br_cnt", 32'(stall_cnt_o), 32'd2);
        idle_inputs();

        // Memory wait: three held cycles, then the ready cycle.
        pulse_reset();
        mem_req_i = 1'b1; mem_ready_i = 1'b0;
        #1 chk("mw_hold0", 32'(ctl), 32'(C_HOLD));
        chk("mw_state0", 32'(state_o), 32'd0);
        tick();
        chk("mw_hold1", 32'(ctl), 32'(C_HOLD));
        chk("mw_state1", 32'(state_o), 32'd1);
        tick();
        chk("mw_hold2", 32'(ctl), 32'(C_HOLD));
        chk("mw_state2", 32'(state_o), 32'd1);
        tick();
        mem_ready_i = 1'b1;
        #1 chk("mw_ready_ctl", 32'(ctl), 32'(C_NORMAL));
        chk("mw_ready_state", 32'(state_o), 32'd1);
        tick();
        chk("mw_back_run", 32'(state_o), 32'd0);
        chk("mw_cnt", 32'(stall_cnt_o), 32'd3);
        idle_inputs();

        // Requester withdraws while waiting.
        mem_req_i = 1'b1;
        tick();
        chk("wd_state_wait", 32'(state_o), 32'd1);
        mem_req_i = 1'b0;
        #1 chk("wd_ctl", 32'(ctl), 32'(C_NORMAL));
        tick();
        chk("wd_state_run", 32'(state_o), 32'd0);
        chk("wd_cnt", 32'(stall_cnt_o), 32'd4);

        // Timeout: ERROR after the 16th stalled edge, held for 20 cycles total.
        mem_req_i = 1'b1; mem_ready_i = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("to_state15", 32'(state_o), 32'd1);
        chk("to_err15", 32'(err_o), 32'd0);
        tick();
        chk("to_state16", 32'(state_o), 32'd2);
        chk("to_err16", 32'(err_o), 32'd1);
        chk("to_ctl16", 32'(ctl), 32'(C_HOLD));
        for (int i = 0; i < 4; i++) tick();
        chk("to_cnt20", 32'(stall_cnt_o), 32'd24);
        // ERROR is terminal even once the request completes.
        mem_ready_i = 1'b1;
        #1 chk("err_hold_ctl", 32'(ctl), 32'(C_HOLD));
        tick();
        chk("err_sticky_state", 32'(state_o), 32'd2);
        chk("err_sticky", 32'(err_o), 32'd1);
        idle_inputs();
        pulse_reset();

        // Saturation of the 4-bit counter.
        set_load_use(5'd12);
        for (int i = 0; i < 15; i++) tick();
        chk("sat_cnt15", 32'(s_stall_cnt), 32'd15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_cnt20", 32'(s_stall_cnt), 32'd15);
        chk("wide_cnt20", 32'(stall_cnt_o), 32'd20);
        idle_inputs();

        // final report
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
